// File: rtl/fp32_normalizer.sv
// Post-add normalizer for fp32: shifts the sum significand left to restore the hidden bit,
// adjusts or flushes the exponent, and packs the result through a two-stage valid/ready pipe.
module fp32_normalizer #(
   parameter int unsigned SIG_W = 24,
   parameter int unsigned EXP_W = 8,
   parameter int unsigned LZ_W  = 5,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             in_sign,
   input  logic [EXP_W-1:0] in_exp,
   input  logic [SIG_W-1:0] in_sig,
   input  logic [LZ_W-1:0]  in_lz,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_result,
   output logic             out_underflow,
   output logic [CNT_W-1:0] uf_count
);

   localparam int unsigned RES_W = 32;

   // Stage 1 payload: classified beat waiting for its shift
   logic             s1_valid_q, s1_valid_d;
   logic             s1_sign_q,  s1_sign_d;
   logic [EXP_W-1:0] s1_exp_q,   s1_exp_d;
   logic [SIG_W-1:0] s1_sig_q,   s1_sig_d;
   logic [LZ_W-1:0]  s1_shift_q, s1_shift_d;
   logic             s1_uf_q,    s1_uf_d;

   logic             out_valid_q,     out_valid_d;
   logic [RES_W-1:0] out_result_q,    out_result_d;
   logic             out_underflow_q, out_underflow_d;
   logic [CNT_W-1:0] uf_count_q,      uf_count_d;

   logic             s2_free;
   logic             in_xfer;
   logic             zero;
   logic [EXP_W-1:0] lz_ext;
   logic [SIG_W-1:0] sig_s;

   assign s2_free  = !out_valid_q || out_ready;
   assign in_ready = !s1_valid_q || s2_free;
   assign in_xfer  = in_valid && in_ready;
   assign zero     = (in_sig == '0);
   assign lz_ext   = EXP_W'(in_lz);
   assign sig_s    = s1_sig_q << s1_shift_q;

   // Stage 1: classify ZERO / DENORM / NORMAL / UFLOW and pick shift and exponent
   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_sign_d  = s1_sign_q;
      s1_exp_d   = s1_exp_q;
      s1_sig_d   = s1_sig_q;
      s1_shift_d = s1_shift_q;
      s1_uf_d    = s1_uf_q;
      if (in_xfer) begin
         s1_valid_d = 1'b1;
         s1_sig_d   = in_sig;
         s1_sign_d  = in_sign && !zero;
         s1_exp_d   = '0;
         s1_shift_d = '0;
         s1_uf_d    = 1'b0;
         if (zero) begin
            s1_uf_d = 1'b0;
         end else if (in_exp == '0) begin
            s1_uf_d = 1'b1;
         end else if (in_exp > lz_ext) begin
            s1_shift_d = in_lz;
            s1_exp_d   = in_exp - lz_ext;
         end else begin
            // in_exp <= in_lz < SIG_W, so in_exp-1 fits the shift field
            s1_shift_d = LZ_W'(in_exp - EXP_W'(1));
            s1_uf_d    = 1'b1;
         end
      end else if (s2_free) begin
         s1_valid_d = 1'b0;
      end
   end

   // Stage 2: apply shift and pack; holds while the consumer stalls
   always_comb begin
      out_valid_d     = out_valid_q;
      out_result_d    = out_result_q;
      out_underflow_d = out_underflow_q;
      if (s2_free) begin
         out_valid_d = s1_valid_q;
         if (s1_valid_q) begin
            out_result_d    = RES_W'({s1_sign_q, s1_exp_q, sig_s[SIG_W-2:0]});
            out_underflow_d = s1_uf_q;
         end
      end
   end

   // Saturating count of delivered underflow results
   always_comb begin
      uf_count_d = uf_count_q;
      if (out_valid_q && out_ready && out_underflow_q && (uf_count_q != '1)) begin
         uf_count_d = uf_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_q      <= 1'b0;
         s1_sign_q       <= 1'b0;
         s1_exp_q        <= '0;
         s1_sig_q        <= '0;
         s1_shift_q      <= '0;
         s1_uf_q         <= 1'b0;
         out_valid_q     <= 1'b0;
         out_result_q    <= '0;
         out_underflow_q <= 1'b0;
         uf_count_q      <= '0;
      end else begin
         s1_valid_q      <= s1_valid_d;
         s1_sign_q       <= s1_sign_d;
         s1_exp_q        <= s1_exp_d;
         s1_sig_q        <= s1_sig_d;
         s1_shift_q      <= s1_shift_d;
         s1_uf_q         <= s1_uf_d;
         out_valid_q     <= out_valid_d;
         out_result_q    <= out_result_d;
         out_underflow_q <= out_underflow_d;
         uf_count_q      <= uf_count_d;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_result    = out_result_q;
   assign out_underflow = out_underflow_q;
   assign uf_count      = uf_count_q;

endmodule
